// File: rtl/multicycle_ctrl_if.sv
// Control bus between the multicycle controller and its instruction memory,
// data memory and datapath. The controller takes the master side.
interface multicycle_ctrl_if #(
   parameter int OPW  = 3,
   parameter int ALUW = 3,
   parameter int CNTW = 16
);
   logic [OPW-1:0]  instr_op;
   logic            instr_ack;
   logic            mem_ack;
   logic            alu_zero;
   logic            instr_req;
   logic            ir_write;
   logic            pc_inc;
   logic            pc_branch;
   logic            mem_req;
   logic            mem_write;
   logic            mem_to_reg;
   logic            alu_src;
   logic            reg_write;
   logic [ALUW-1:0] alu_op;
   logic            trap;
   logic [1:0]      err_code;
   logic [CNTW-1:0] retired;

   modport master (
      input  instr_op, instr_ack, mem_ack, alu_zero,
      output instr_req, ir_write, pc_inc, pc_branch, mem_req, mem_write,
             mem_to_reg, alu_src, reg_write, alu_op, trap, err_code, retired
   );

   modport slave (
      output instr_op, instr_ack, mem_ack, alu_zero,
      input  instr_req, ir_write, pc_inc, pc_branch, mem_req, mem_write,
             mem_to_reg, alu_src, reg_write, alu_op, trap, err_code, retired
   );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle processor control FSM: fetch / decode / execute / memory /
// write-back sequencing with handshake timeouts, illegal-opcode trap and a
// retired-instruction counter.
module multicycle_ctrl #(
   parameter int OPW  = 3,
   parameter int ALUW = 3,
   parameter int TMO  = 16,
   parameter int CNTW = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   multicycle_ctrl_if.master bus
);
   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
   } state_t;

   // Wait counter only needs to reach TMO-1: the TMO-th waiting cycle is the last.
   localparam int               WCW       = $clog2(TMO + 1);
   localparam logic [WCW-1:0]   WAIT_LAST = WCW'(TMO - 1);

   localparam logic [2:0] OP_XOR = 3'd0;
   localparam logic [2:0] OP_BEQ = 3'd1;
   localparam logic [2:0] OP_LD  = 3'd5;
   localparam logic [2:0] OP_ST  = 3'd6;
   localparam logic [2:0] OP_J   = 3'd7;

   state_t          state_reg, state_next;
   logic [OPW-1:0]  op_q;
   logic [WCW-1:0]  wait_cnt_reg;
   logic [1:0]      err_code_reg, err_code_next;
   logic [CNTW-1:0] retired_reg;
   logic            retire;
   logic            waiting;
   logic            timeout;
   logic            illegal_op;
   logic [2:0]      op3;

   assign op3     = op_q[2:0];
   assign timeout = (wait_cnt_reg == WAIT_LAST);
   assign waiting = ((state_reg == S_FETCH) && !bus.instr_ack) ||
                    ((state_reg == S_MEM)   && !bus.mem_ack);

   // Opcodes of 8 and above only exist when the opcode field is wider than 3 bits.
   generate
      if (OPW > 3) begin : g_wide_op
         assign illegal_op = |op_q[OPW-1:3];
      end else begin : g_narrow_op
         assign illegal_op = 1'b0;
      end
   endgenerate

   assign bus.err_code = err_code_reg;
   assign bus.retired  = retired_reg;

   // State, latched opcode, handshake wait counter, error code and retire counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= S_IDLE;
         op_q         <= '0;
         wait_cnt_reg <= '0;
         err_code_reg <= 2'b00;
         retired_reg  <= '0;
      end else begin
         state_reg    <= state_next;
         err_code_reg <= err_code_next;
         if ((state_reg == S_FETCH) && bus.instr_ack)
            op_q <= bus.instr_op;
         if (state_next != state_reg)
            wait_cnt_reg <= '0;
         else if (waiting)
            wait_cnt_reg <= wait_cnt_reg + WCW'(1);
         if (retire)
            retired_reg <= retired_reg + CNTW'(1);
      end
   end

   // Next-state logic and control outputs decoded from state and op_q.
   always_comb begin
      state_next     = state_reg;
      err_code_next  = err_code_reg;
      retire         = 1'b0;
      bus.instr_req  = 1'b0;
      bus.ir_write   = 1'b0;
      bus.pc_inc     = 1'b0;
      bus.pc_branch  = 1'b0;
      bus.mem_req    = 1'b0;
      bus.mem_write  = 1'b0;
      bus.mem_to_reg = 1'b0;
      bus.alu_src    = 1'b0;
      bus.reg_write  = 1'b0;
      bus.alu_op     = '0;
      bus.trap       = 1'b0;
      case (state_reg)
         S_IDLE: state_next = S_FETCH;
         S_FETCH: begin
            bus.instr_req = 1'b1;
            if (bus.instr_ack) begin
               bus.ir_write = 1'b1;
               bus.pc_inc   = 1'b1;
               state_next   = S_DECODE;
            end else if (timeout) begin
               state_next    = S_TRAP;
               err_code_next = 2'b10;
            end
         end
         S_DECODE: begin
            if (illegal_op) begin
               state_next    = S_TRAP;
               err_code_next = 2'b01;
            end else begin
               state_next = S_EXEC;
            end
         end
         S_EXEC: begin
            // The j encoding 3'b111 is also its ALU code, so one zero-extend covers all ops.
            bus.alu_op  = ALUW'(op3);
            bus.alu_src = (op3 != OP_XOR) && (op3 != OP_J);
            case (op3)
               OP_BEQ: begin
                  bus.pc_branch = bus.alu_zero;
                  state_next    = S_FETCH;
                  retire        = 1'b1;
               end
               OP_J: begin
                  bus.pc_branch = 1'b1;
                  state_next    = S_FETCH;
                  retire        = 1'b1;
               end
               OP_LD, OP_ST: state_next = S_MEM;
               default:      state_next = S_WB;
            endcase
         end
         S_MEM: begin
            bus.mem_req   = 1'b1;
            bus.mem_write = (op3 == OP_ST);
            bus.alu_src   = 1'b1;
            if (bus.mem_ack) begin
               if (op3 == OP_ST) begin
                  state_next = S_FETCH;
                  retire     = 1'b1;
               end else begin
                  state_next = S_WB;
               end
            end else if (timeout) begin
               state_next    = S_TRAP;
               err_code_next = 2'b10;
            end
         end
         S_WB: begin
            bus.reg_write  = 1'b1;
            bus.mem_to_reg = (op3 == OP_LD);
            state_next     = S_FETCH;
            retire         = 1'b1;
         end
         S_TRAP:  bus.trap  = 1'b1;
         default: state_next = S_IDLE;
      endcase
   end
endmodule
